// File: rtl/ram512_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ram512_arbiter - round-robin two-requester sequencer for the single-port RAM512
// (512 x 16); define RAM512_ARB_LOCK_EN for atomic-burst locking.  Rev 1.0
// ---------------------------------------------------------------------------
module ram512_arbiter #(
  parameter int AW       = 9,
  parameter int DW       = 16,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_a,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] wdata_a,
  input  logic          req_b,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] wdata_b,
`ifdef RAM512_ARB_LOCK_EN
  input  logic          lock_a,
  input  logic          lock_b,
`endif
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          rvalid_a,
  output logic          rvalid_b,
  output logic [DW-1:0] rdata,
  output logic          mem_load,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_in,
  input  logic [DW-1:0] mem_out
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  // Without the lock option the lock path is tied off and folds away.
  logic lock_a_eff, lock_b_eff;
`ifdef RAM512_ARB_LOCK_EN
  assign lock_a_eff = lock_a;
  assign lock_b_eff = lock_b;
`else
  assign lock_a_eff = 1'b0;
  assign lock_b_eff = 1'b0;
`endif

  logic          prio_q, prio_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          lock_own_q, lock_own_d;
  logic          gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic          mem_load_q, mem_load_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_in_q, mem_in_d;
  logic [1:0]    tag1_q, tag1_d, tag2_q, tag2_d;  // {read in flight, owner is B}
  logic          rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          lock_limit, forced, favour_b, win_a, win_b, win_we, win_lock;

  always_comb begin
    lock_limit = (lock_cnt_q == CW'(LOCK_MAX));
    forced     = lock_limit & req_a & req_b;
    favour_b   = forced ? ~lock_own_q : prio_q;
    win_a      = req_a & (~req_b | ~favour_b);
    win_b      = req_b & ~win_a;
    win_we     = win_a ? we_a : we_b;
    win_lock   = win_a ? lock_a_eff : (win_b & lock_b_eff);

    // A locked winner keeps priority; the run length saturates at LOCK_MAX.
    prio_d     = prio_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = '0;
    if (win_lock && !forced) begin
      prio_d     = win_b;
      lock_own_d = win_b;
      if (lock_cnt_q != '0 && lock_own_q == win_b)
        lock_cnt_d = lock_limit ? lock_cnt_q : lock_cnt_q + CW'(1);
      else
        lock_cnt_d = CW'(1);
    end else if (win_a || win_b) begin
      prio_d = win_a;
    end

    mem_load_d    = 1'b0;
    mem_address_d = mem_address_q;
    mem_in_d      = mem_in_q;
    if (win_a) begin
      mem_load_d    = we_a;
      mem_address_d = addr_a;
      mem_in_d      = wdata_a;
    end else if (win_b) begin
      mem_load_d    = we_b;
      mem_address_d = addr_b;
      mem_in_d      = wdata_b;
    end

    gnt_a_d    = win_a;
    gnt_b_d    = win_b;
    tag1_d     = {(win_a | win_b) & ~win_we, win_b};
    tag2_d     = tag1_q;
    rvalid_a_d = tag2_q[1] & ~tag2_q[0];
    rvalid_b_d = tag2_q[1] & tag2_q[0];
    rdata_d    = tag2_q[1] ? mem_out : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q        <= 1'b0;
      lock_cnt_q    <= '0;
      lock_own_q    <= 1'b0;
      gnt_a_q       <= 1'b0;
      gnt_b_q       <= 1'b0;
      mem_load_q    <= 1'b0;
      mem_address_q <= '0;
      mem_in_q      <= '0;
      tag1_q        <= '0;
      tag2_q        <= '0;
      rvalid_a_q    <= 1'b0;
      rvalid_b_q    <= 1'b0;
      rdata_q       <= '0;
    end else begin
      prio_q        <= prio_d;
      lock_cnt_q    <= lock_cnt_d;
      lock_own_q    <= lock_own_d;
      gnt_a_q       <= gnt_a_d;
      gnt_b_q       <= gnt_b_d;
      mem_load_q    <= mem_load_d;
      mem_address_q <= mem_address_d;
      mem_in_q      <= mem_in_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag2_d;
      rvalid_a_q    <= rvalid_a_d;
      rvalid_b_q    <= rvalid_b_d;
      rdata_q       <= rdata_d;
    end
  end

  assign gnt_a       = gnt_a_q;
  assign gnt_b       = gnt_b_q;
  assign rvalid_a    = rvalid_a_q;
  assign rvalid_b    = rvalid_b_q;
  assign rdata       = rdata_q;
  assign mem_load    = mem_load_q;
  assign mem_address = mem_address_q;
  assign mem_in      = mem_in_q;

endmodule

`default_nettype wire

// File: doc/ram512_arbiter.md
# ram512_arbiter

Two-requester arbiter and sequencer in front of the single-port 512 x 16 RAM512 memory. It accepts independent read/write requests from requester A and requester B, such as the CPU data port and a DMA/screen engine. It serialises them onto the memory's load/address/in pins with round-robin fairness and returns read data to the owning requester with a valid strobe. It issues one memory command per cycle, fully pipelined, and owns the only path to the memory.

## Interface
Parameters:
- `AW`, 9: memory address width (512 words).
- `DW`, 16: data width.
- `LOCK_MAX`, 16: maximum consecutive locked grants. Only used when locking is compiled in.

Ports:
- `clk`  in  1: the single clock. All state changes on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_a` / `req_b`  in  1: request valid. The command fields must be held stable while req is high and gnt is low.
- `we_a` / `we_b`  in  1: 1 = write, 0 = read.
- `addr_a` / `addr_b`  in  AW: word address.
- `wdata_a` / `wdata_b`  in  DW: write data.
- `gnt_a` / `gnt_b`  out  1: one-cycle registered grant. The request was accepted.
- `rvalid_a` / `rvalid_b`  out  1: one-cycle read-data-valid for that requester.
- `rdata`  out  DW: shared read data. Only meaningful while an rvalid is high.
- `mem_load`  out  1: to RAM512 `load`.
- `mem_address`  out  AW: to RAM512 `address`.
- `mem_in`  out  DW: to RAM512 `in`.
- `mem_out`  in  DW: from RAM512 `out`. It is registered in the memory and updates on the edge at which `mem_address` is sampled.
- `lock_a` / `lock_b`  in  1: present only with `RAM512_ARB_LOCK_EN`.

## Operation
- **Arbitration:** performed every edge on the sampled `req_a`/`req_b`.
  - Only one requesting: it wins.
  - Both requesting: the winner is chosen by the priority pointer `prio`.
  - `prio` = 0 favours A; `prio` = 1 favours B.
- **Pointer update:** after any grant, `prio` points at the requester that was not granted (rotation). No grant leaves `prio` unchanged.
- **Command issue:** on the winning edge, the winner's command is registered onto the `mem_*` outputs.
  - `mem_load` = winner's `we`.
  - `mem_address` = winner's addr.
  - `mem_in` = winner's wdata.
  - The matching `gnt_x` is set for that single cycle.
- **Idle:** with no winner, `mem_load` = 0; `mem_address`/`mem_in` hold their previous values.
- **Read tracking:** a 2-stage shift of {valid, owner} tags follows each read.
  - Stage 1 is set with the grant.
  - Stage 2 on the next edge, when the arbiter registers `mem_out` into `rdata` and pulses `rvalid_owner`.
  - Writes produce no rvalid.
- **States:** `rst` (async) -> `RUN`. In RUN, the pipeline tags carry any in-flight reads; there is no other stall state.
- **Requester rule:** seeing `gnt_x` high, the requester drops `req_x` or presents the next command before the following edge. A `req_x` still high at that edge is a new request.

## Timing
- **Reset values:** while `rst_n` is low, and immediately on its falling edge:
  - `gnt_a`, `gnt_b`, `rvalid_a`, `rvalid_b`, `mem_load` = 0.
  - `mem_address` = 0, `mem_in` = 0, `rdata` = 0.
  - `prio` = 0, pipeline tags cleared, lock counter = 0.
- **Latency:** request sampled at edge N:
  - `gnt` and `mem_*` are valid in cycle N..N+1.
  - Memory acts at edge N+1.
  - `rdata`/`rvalid` are valid in cycle N+2..N+3.
- **Throughput:** 1 command per cycle. Alternating A/B under continuous contention.
- **Read-after-write, same address:**
  - Write granted at edge N, read granted at edge N+1: the read returns the new data.
  - Both target the same edge: impossible, because only one command is issued per edge.
- **Reset mid-read:** in-flight reads are discarded. No rvalid is produced after reset is released.
- **Address wrap:** none. Addresses are exactly AW bits.

## Configuration
- **`RAM512_ARB_LOCK_EN` defined:** adds `lock_a`/`lock_b` for atomic bursts.
  - A winner granted with its lock high keeps priority on subsequent edges. `prio` does not rotate.
  - A counter caps locked grants. After `LOCK_MAX` consecutive locked grants, if the other requester is waiting, the next grant goes to the other requester and the counter clears.
  - Dropping lock or req clears the counter.
- **`RAM512_ARB_LOCK_EN` undefined:** there are no lock ports and pure round-robin applies.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream.
  - All outputs become 0 asynchronously.
  - A read granted one edge before reset produces no `rvalid_a`/`rvalid_b` after release.
- **Single read:** A writes 0x1234 to address 5. B then reads address 5 on the next cycle.
  - `gnt_b` follows `gnt_a` by one cycle.
  - `rvalid_b` is high 2 cycles after `gnt_b` with `rdata` = 0x1234.
- **Contention:** A and B request reads continuously for 8 cycles.
  - Grants alternate A, B, A, ... starting with A after reset.
  - 4 `rvalid_a` and 4 `rvalid_b` pulses, each with the correct data.
- **Edges:** write 0xFFFF to address 511 and 0x0001 to address 0, then read both.
  - Returns 0xFFFF and 0x0001.
  - `mem_address` never exceeds 9 bits.
- **Idle/hold:** no requests for 5 cycles after activity.
  - `mem_load` = 0 and no gnt/rvalid pulses.
  - `prio` is unchanged: the next simultaneous request is granted to the side not served last.
- **Lock (`RAM512_ARB_LOCK_EN`):** A holds lock and req for 20 cycles while B requests throughout.
  - A is granted 16 times.
  - B is granted on the 17th grant.
  - A resumes afterwards.
